// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if
//   Groups the control, data and display signals of the four-digit
//   7-segment scan controller into one bundle.
//
//   Signals:
//     en     : scanning enable (1 = scan the digits)
//     load   : capture request, sampled on each rising clock edge
//     data   : four hex nibbles, digit k = data[4k+3:4k], digit 0 rightmost
//     lz_en  : leading-zero blanking enable
//     bin    : registered nibble of the active digit, to the segment decoder
//     an     : registered active-low digit enables (4'b1111 = all off)
//     tick   : one-cycle pulse after each digit advance
//     pend   : a captured value is waiting for the next frame boundary
//
//   The master modport is the controlling side (drives en/load/data/lz_en).
//   The slave modport is the scan controller itself.
interface seven_seg_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic        lz_en;
  logic [3:0]  bin;
  logic [3:0]  an;
  logic        tick;
  logic        pend;

  modport master (
    output en, load, data, lz_en,
    input  bin, an, tick, pend
  );

  modport slave (
    input  en, load, data, lz_en,
    output bin, an, tick, pend
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexes a 16-bit value across four common-anode 7-segment
//   digits. Each digit stays lit for CLK_DIV clock cycles. New values are
//   captured into a pending register and only copied into the display
//   register when the scan wraps from digit 3 back to digit 0, so a frame
//   never shows a mix of old and new digits. Optional leading-zero blanking
//   switches off upper digits that hold only zeros.
//
//   Parameters:
//     CLK_DIV : clock cycles per digit, 2 .. 2**20
//
//   Ports:
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset (release synchronised outside)
//     bus    : slave side of seven_seg_scan_ctrl_if (en, load, data, lz_en
//              in; bin, an, tick, pend out)
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  bus
);

  // Counter just wide enough to hold CLK_DIV-1.
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pending;
  logic          pend_q;
  logic [3:0]    bin_q;
  logic [3:0]    an_q;
  logic          tick_q;

  logic          digit_edge;
  logic          commit;
  logic [1:0]    idx_next;
  logic [15:0]   disp_next;
  logic [3:0]    bin_next;
  logic [3:0]    an_next;

  // Nibble k of a 16-bit display word.
  function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] k);
    logic [3:0] n;
    case (k)
      2'd0:    n = d[3:0];
      2'd1:    n = d[7:4];
      2'd2:    n = d[11:8];
      default: n = d[15:12];
    endcase
    return n;
  endfunction

  // Digit k is a leading zero when it and every digit above it are zero;
  // digit 0 is always shown so that a zero value still displays "0".
  function automatic logic is_leading_zero(input logic [15:0] d, input logic [1:0] k);
    logic z;
    case (k)
      2'd1:    z = (d[15:4] == 12'h000);
      2'd2:    z = (d[15:8] == 8'h00);
      2'd3:    z = (d[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Work out the next digit and the value it will show. The commit point is
  // the 3->0 wrap while scanning, or any edge while scanning is disabled, so
  // that a value loaded while the display is idle is taken over at once.
  // The digit-0 nibble of a wrapping edge uses the freshly committed word.
  always_comb begin
    digit_edge = 1'b0;
    commit     = 1'b0;
    idx_next   = 2'd0;
    disp_next  = disp;
    bin_next   = 4'h0;
    an_next    = 4'b1111;

    digit_edge = bus.en && (presc == LAST);
    commit     = pend_q && ((digit_edge && (idx == 2'd3)) || !bus.en);
    idx_next   = idx + 2'd1;
    if (commit) begin
      disp_next = pending;
    end
    bin_next = nibble(disp_next, idx_next);
    if (bus.lz_en && is_leading_zero(disp_next, idx_next)) begin
      an_next = 4'b1111;
    end else begin
      an_next = ~(4'b0001 << idx_next);
    end
  end

  // All sequential state. Loading always lands in the pending register (a
  // load on a commit edge still hands the old pending word to the display,
  // so pend stays set). With scanning off the display is dark and parked on
  // digit 0; on the first enabled edge digit 0 lights again while the
  // prescaler begins its first full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= 2'd0;
      disp    <= 16'h0000;
      pending <= 16'h0000;
      pend_q  <= 1'b0;
      bin_q   <= 4'h0;
      an_q    <= 4'b1110;
      tick_q  <= 1'b0;
    end else begin
      if (bus.load) begin
        pending <= bus.data;
        pend_q  <= 1'b1;
      end else if (commit) begin
        pend_q  <= 1'b0;
      end

      if (commit) begin
        disp <= pending;
      end

      if (!bus.en) begin
        presc  <= '0;
        idx    <= 2'd0;
        tick_q <= 1'b0;
        an_q   <= 4'b1111;
        bin_q  <= disp_next[3:0];
      end else if (digit_edge) begin
        presc  <= '0;
        idx    <= idx_next;
        tick_q <= 1'b1;
        an_q   <= an_next;
        bin_q  <= bin_next;
      end else begin
        presc  <= presc + 1'b1;
        tick_q <= 1'b0;
        if (idx == 2'd0) begin
          an_q  <= 4'b1110;
          bin_q <= disp[3:0];
        end
      end
    end
  end

  assign bus.bin  = bin_q;
  assign bus.an   = an_q;
  assign bus.tick = tick_q;
  assign bus.pend = pend_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000, SHALL set the clock cycles each digit is displayed; legal range 2..2^20.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RESET_N  input  1  SHALL be the reset: asynchronous and active-low.
REQ-004 EN  input  1  SHALL enable scanning when 1.
REQ-005 LOAD  input  1  SHALL request capture of DATA on a rising CLK edge where LOAD=1.
REQ-006 DATA  input  16  SHALL carry four hex nibbles: digit k = DATA[4k+3:4k], digit 0 rightmost.
REQ-007 LZ_EN  input  1  SHALL enable leading-zero blanking when 1.
REQ-008 BIN  output  4  SHALL carry the registered nibble for the active digit, driving the downstream 7-segment decoder input.
REQ-009 AN  output  4  SHALL carry the registered active-low digit enables, one-hot-low; 4'b1111 = all off.
REQ-010 TICK  output  1  SHALL pulse high for exactly one cycle on each digit advance.
REQ-011 PEND  output  1  SHALL be 1 while a captured value awaits commit.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 while EN=1; the edge at CLK_DIV-1 is a "digit edge": prescaler returns to 0, TICK=1 next cycle.
REQ-013 Digit index SHALL advance 0->1->2->3->0 on each digit edge; no other transitions.
REQ-014 BIN and AN SHALL update on the same edge as the index, reflecting the new index; steady between digit edges.
REQ-015 AN SHALL be 4'b1110, 1101, 1011, 0111 for index 0,1,2,3 when not blanked.
REQ-016 LOAD edge SHALL write DATA into pending register and set PEND=1; later LOADs before commit overwrite pending (last wins).
REQ-017 Commit SHALL occur only on the digit edge where index wraps 3->0: if PEND=1, display register <= pending, PEND <= 0; BIN for digit 0 on that edge uses the newly committed value (no tearing within a frame).
REQ-018 LOAD coincident with a commit edge: display gets previous pending; pending gets new DATA; PEND stays 1.
REQ-019 LOAD coincident with commit edge while PEND=0: DATA goes to pending, PEND=1, display unchanged until next wrap.
REQ-020 LZ_EN=1: digit k>=1 SHALL be blanked (AN=4'b1111, BIN still driven with nibble) when display nibbles k..3 are all zero; digit 0 never blanked.
REQ-021 LZ_EN SHALL be sampled combinationally at each digit edge; change takes effect from next digit edge.
REQ-022 EN=0: prescaler and index held at 0, AN=4'b1111, TICK=0, BIN=display nibble 0; LOAD capture continues; commit SHALL occur immediately on next edge while EN=0 and PEND=1.
REQ-023 EN 0->1: first digit edge after CLK_DIV cycles, advancing to index 1; AN=4'b1110 from the first EN=1 edge.

Reset
REQ-024 RESET_N=0 SHALL immediately (asynchronously) force prescaler=0, index=0, display=0, pending=0, PEND=0, BIN=0, TICK=0, AN=4'b1110.
REQ-025 Reset asserted mid-frame or with PEND=1 SHALL discard pending data; after release scanning restarts at digit 0, full CLK_DIV period.
REQ-026 Release of RESET_N SHALL be assumed synchronised externally; no internal synchroniser.

Verification (CLK_DIV=4)
REQ-027 Reset release, EN=1, LZ_EN=0, no LOAD -> TICK every 4 cycles, AN sequence 1110,1101,1011,0111,1110..., BIN=0 throughout.
REQ-028 LOAD DATA=16'h12AF mid-frame at index 1 -> PEND=1; display unchanged until 3->0 wrap; then BIN sequence F,A,2,1, PEND=0.
REQ-029 LOAD 16'h1111 then 16'h2222 before wrap -> only 2 digits shown after wrap (last wins); LOAD 16'h3333 on wrap edge -> 2222 shown this frame, 3333 next, PEND stays 1 across wrap.
REQ-030 LZ_EN=1, committed 16'h0050 -> AN over a frame 1110,1101,1111,1111; committed 16'h0000 -> only digit 0 lit, BIN=0.
REQ-031 EN=0 with PEND=1 -> commit next edge, AN=4'b1111, TICK=0; EN=1 -> AN=1110, TICK after 4 cycles.
REQ-032 RESET_N pulsed low at index 2 with PEND=1 -> outputs reset values without clock edge, PEND=0, prior display lost.
